// File: rtl/half_adder_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : half_adder_bist_pkg
// Brief    : Shared FSM encodings, MISR geometry and default constants for
//            the half-adder BIST controller.
// Revision : 1.0
// ============================================================================
package half_adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int          c_MISR_W         = 4;
  localparam int          c_TAP_HI         = 3;
  localparam int          c_TAP_LO         = 2;
  localparam logic [1:0]  c_CNT_LAST       = 2'd3;
  localparam logic [3:0]  c_DEFAULT_SEED   = 4'h0;
  localparam logic [3:0]  c_DEFAULT_GOLDEN = 4'h4;

  // One compaction step: shift left with tap feedback, then fold in {c,s}.
  function automatic logic [c_MISR_W-1:0] misr_step(
    input logic [c_MISR_W-1:0] cur,
    input logic [1:0]          resp
  );
    return {cur[c_MISR_W-2:0], cur[c_TAP_HI] ^ cur[c_TAP_LO]}
           ^ {{(c_MISR_W-2){1'b0}}, resp};
  endfunction

endpackage
`default_nettype wire

// File: rtl/half_adder_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : half_adder_bist_if
// Brief    : Test-access side control/status bundle of the half-adder BIST.
// Revision : 1.0
// ============================================================================
interface half_adder_bist_if;
  import half_adder_bist_pkg::*;

  logic                start;
  logic                fault_inject;
  logic                busy;
  logic                done;
  logic                pass;
  logic [c_MISR_W-1:0] signature;

  modport master (
    output start,
    output fault_inject,
    input  busy,
    input  done,
    input  pass,
    input  signature
  );

  modport slave (
    input  start,
    input  fault_inject,
    output busy,
    output done,
    output pass,
    output signature
  );

endinterface
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module   : half_adder
// Brief    : Single-bit half adder, the cell exercised by the BIST.
// Revision : 1.0
// ============================================================================
module half_adder (
  input  wire logic a,
  input  wire logic b,
  output logic      s,
  output logic      c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule
`default_nettype wire

// File: rtl/half_adder_bist_misr4.sv
`default_nettype none
// ============================================================================
// Module   : misr4
// Brief    : 4-bit multiple-input signature register with synchronous load.
// Revision : 1.0
// ============================================================================
module misr4
  import half_adder_bist_pkg::*;
#(
  parameter logic [c_MISR_W-1:0] RESET_VAL = c_DEFAULT_SEED
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic                load,
  input  wire logic [c_MISR_W-1:0] load_val,
  input  wire logic                en,
  input  wire logic [1:0]          d,
  output logic      [c_MISR_W-1:0] q
);

  logic [c_MISR_W-1:0] r_misr;

  // Load wins over compaction so a restart always begins from the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misr <= RESET_VAL;
    end else if (load) begin
      r_misr <= load_val;
    end else if (en) begin
      r_misr <= misr_step(r_misr, d);
    end
  end

  assign q = r_misr;

endmodule
`default_nettype wire

// File: rtl/half_adder_bist.sv
`default_nettype none
// ============================================================================
// Module   : half_adder_bist
// Brief    : Exhaustive-pattern BIST controller for the half_adder cell with
//            MISR response compaction and golden-signature compare.
// Revision : 1.0
// ============================================================================
module half_adder_bist
  import half_adder_bist_pkg::*;
#(
  parameter logic [c_MISR_W-1:0] SEED   = c_DEFAULT_SEED,
  parameter logic [c_MISR_W-1:0] GOLDEN = c_DEFAULT_GOLDEN
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  half_adder_bist_if.slave  bus
);

  state_t              r_state;
  logic [1:0]          r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;

  logic                w_run;
  logic                w_accept;
  logic                w_a;
  logic                w_b;
  logic                w_s;
  logic                w_c;
  logic [1:0]          w_resp;
  logic [c_MISR_W-1:0] w_sig;
  logic [c_MISR_W-1:0] w_misr_next;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = bus.start && (r_state != ST_RUN);

  // Cell inputs are parked at 0 outside of RUN.
  assign w_a = w_run & r_cnt[1];
  assign w_b = w_run & r_cnt[0];

  half_adder u_half_adder (
    .a (w_a),
    .b (w_b),
    .s (w_s),
    .c (w_c)
  );

  assign w_resp      = {w_c, w_s ^ bus.fault_inject};
  assign w_misr_next = misr_step(w_sig, w_resp);

  misr4 #(
    .RESET_VAL (SEED)
  ) u_misr4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_accept),
    .load_val (SEED),
    .en       (w_run),
    .d        (w_resp),
    .q        (w_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 2'd1;
          // Terminal count ends the session; the compare sees the final fold.
          if (r_cnt == c_CNT_LAST) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_misr_next == GOLDEN);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 2'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.signature = w_sig;

endmodule
`default_nettype wire

// File: tb/tb_half_adder_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_adder_bist
// Brief    : Directed self-checking bench for half_adder_bist.
// Revision : 1.0
// ============================================================================
module tb_half_adder_bist;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  half_adder_bist_if bus  ();
  half_adder_bist_if bus5 ();

  half_adder_bist dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  half_adder_bist #(
    .GOLDEN (4'h5)
  ) dut_g5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  task automatic test_reset();
    bus.start = 1'b0; bus.fault_inject = 1'b0;
    bus5.start = 1'b0; bus5.fault_inject = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.signature} !== 7'b000_0000) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b pass=%b sig=%h want 0 0 0 0",
               bus.busy, bus.done, bus.pass, bus.signature);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_fault_free();
    logic [15:0] exp = 16'h4310;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.signature} !== 6'b10_0000) begin
      failures++;
      $display("FAIL ff_after_e0 got busy=%b done=%b sig=%h want 1 0 0",
               bus.busy, bus.done, bus.signature);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.signature !== exp[i*4 +: 4] || bus.busy !== (i < 3) || bus.done !== (i == 3)) begin
        failures++;
        $display("FAIL ff_e%0d got sig=%h busy=%b done=%b want sig=%h busy=%b done=%b",
                 i + 1, bus.signature, bus.busy, bus.done, exp[i*4 +: 4], i < 3, i == 3);
      end
    end
    checks++;
    if (bus.pass !== 1'b1) begin
      failures++;
      $display("FAIL ff_pass got %b want 1", bus.pass);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.done, bus.pass, bus.signature} !== 6'b11_0100) begin
      failures++;
      $display("FAIL ff_hold got done=%b pass=%b sig=%h want 1 1 4",
               bus.done, bus.pass, bus.signature);
    end
  endtask

  // Leaves the DUT in its first DONE cycle for the back-to-back restart.
  task automatic test_fault_inject();
    logic [15:0] exp = 16'hA421;
    bus.start = 1'b1; bus.fault_inject = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.signature !== exp[i*4 +: 4]) begin
        failures++;
        $display("FAIL fi_e%0d got sig=%h want %h", i + 1, bus.signature, exp[i*4 +: 4]);
      end
    end
    checks++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b010) begin
      failures++;
      $display("FAIL fi_done got busy=%b done=%b pass=%b want 0 1 0",
               bus.busy, bus.done, bus.pass);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp = 16'h4310;
    bus.start = 1'b1; bus.fault_inject = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.signature} !== 7'b100_0000) begin
      failures++;
      $display("FAIL b2b_restart got busy=%b done=%b pass=%b sig=%h want 1 0 0 0",
               bus.busy, bus.done, bus.pass, bus.signature);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.signature !== exp[i*4 +: 4]) begin
        failures++;
        $display("FAIL b2b_e%0d got sig=%h want %h", i + 1, bus.signature, exp[i*4 +: 4]);
      end
    end
    checks++;
    if ({bus.done, bus.pass} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_done got done=%b pass=%b want 1 1", bus.done, bus.pass);
    end
  endtask

  task automatic test_reset_mid_run();
    int stray_done = 0;
    bus.start = 1'b1; bus.fault_inject = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.signature !== 4'h1) begin
      failures++;
      $display("FAIL rst_pre_sig got %h want 1", bus.signature);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.signature} !== 7'b000_0000) begin
      failures++;
      $display("FAIL rst_mid_outputs got busy=%b done=%b pass=%b sig=%h want 0 0 0 0",
               bus.busy, bus.done, bus.pass, bus.signature);
    end
    bus.fault_inject = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray_done++;
    end
    checks++;
    if (stray_done != 0) begin
      failures++;
      $display("FAIL rst_no_done got %0d active cycles want 0", stray_done);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.done, bus.pass, bus.signature} !== 6'b11_0100) begin
      failures++;
      $display("FAIL rst_clean_run got done=%b pass=%b sig=%h want 1 1 4",
               bus.done, bus.pass, bus.signature);
    end
  endtask

  task automatic test_start_in_run();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.signature} !== 6'b10_0011) begin
      failures++;
      $display("FAIL sir_e3 got busy=%b done=%b sig=%h want 1 0 3",
               bus.busy, bus.done, bus.signature);
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.signature} !== 7'b011_0100) begin
      failures++;
      $display("FAIL sir_done got busy=%b done=%b pass=%b sig=%h want 0 1 1 4",
               bus.busy, bus.done, bus.pass, bus.signature);
    end
  endtask

  task automatic test_golden_override();
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({bus5.done, bus5.pass, bus5.signature} !== 6'b10_0100) begin
      failures++;
      $display("FAIL golden5 got done=%b pass=%b sig=%h want 1 0 4",
               bus5.done, bus5.pass, bus5.signature);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_fault_inject();
    test_back_to_back();
    test_reset_mid_run();
    test_start_in_run();
    test_golden_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
